// File: rtl/mmio_uart_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_pkg
// Brief    : Register map, status bit positions and serializer states shared
//            by the MMIO UART queue and its bench.
// Revision : 1.0
// ============================================================================
package mmio_uart_pkg;

    localparam logic [31:0] ADDR_STATUS   = 32'hFFFF_FFF0;
    localparam logic [31:0] ADDR_RX_POP   = 32'hFFFF_FFF1;
    localparam logic [31:0] ADDR_RX_COUNT = 32'hFFFF_FFF2;
    localparam logic [31:0] ADDR_TX_PUSH  = 32'hFFFF_FFF4;
    localparam logic [31:0] ADDR_TX_FREE  = 32'hFFFF_FFF8;

    localparam int STAT_RX_OVF      = 0;
    localparam int STAT_TX_OVF      = 1;
    localparam int STAT_RX_NONEMPTY = 2;
    localparam int STAT_TX_IDLE     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/mmio_uart_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_queue_if
// Brief    : Core data-port and UART byte-engine signals of the MMIO UART queue.
// Revision : 1.0
// ============================================================================
interface mmio_uart_queue_if #(
    parameter int DATA_W = 32
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              access;
    logic              write_enable;
    logic [31:0]       address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              tx_start;
    logic [7:0]        sdata;
    logic              tx_busy;
    logic              irq;

    modport master (
        output rx_valid, rx_data, access, write_enable, address, write_data, tx_busy,
        input  read_data, tx_start, sdata, irq
    );

    modport slave (
        input  rx_valid, rx_data, access, write_enable, address, write_data, tx_busy,
        output read_data, tx_start, sdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_queue_ring_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ring_fifo
// Brief    : Power-of-two ring buffer with count register, full-capacity use
//            and optional drop-oldest on overflow.
// Revision : 1.0
// ============================================================================
module ring_fifo #(
    parameter int W         = 32,
    parameter int DEPTH     = 8,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;
    logic          do_write;
    logic          grow;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_write = 1'b0;
        grow     = 1'b0;
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        if (push && (!full || do_pop)) begin
            do_write = 1'b1;
            grow     = 1'b1;
        end else if (push && OVERWRITE) begin
            // Full and no pop: the new word replaces the oldest one.
            do_write = 1'b1;
            rptr_d   = rptr_q + 1'b1;
        end
        if (do_write) wptr_d = wptr_q + 1'b1;
        if (do_pop)   rptr_d = rptr_q + 1'b1;
        if (grow && !do_pop)      count_d = count_q + 1'b1;
        else if (!grow && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) mem_q[wptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_queue.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_queue
// Brief    : MMIO bridge with RX word ring, TX word ring + byte serializer,
//            sticky overflow flags and status/clear register.
// Revision : 1.0
// ============================================================================
module mmio_uart_queue
    import mmio_uart_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int RX_DEPTH     = 256,
    parameter int TX_DEPTH     = 8,
    parameter bit RX_OVERWRITE = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    mmio_uart_queue_if.slave   bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int RXCW  = $clog2(RX_DEPTH) + 1;
    localparam int TXCW  = $clog2(TX_DEPTH) + 1;

    logic              sel_status, sel_rx_pop, sel_rx_count, sel_tx_push, sel_tx_free;
    logic              rx_pop_req, tx_push_req, status_wr;
    logic              rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic [RXCW-1:0]   rx_count;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;
    logic [TXCW-1:0]   tx_count;
    logic              tx_idle;
    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_q, tx_ovf_d;
    ser_state_e        state_q, state_d;
    logic [BW-1:0]     byte_idx_q, byte_idx_d;
    logic [7:0]        sdata_q, sdata_d;
    logic [DATA_W-1:0] read_data;

    assign sel_status   = (bus.address == ADDR_STATUS);
    assign sel_rx_pop   = (bus.address == ADDR_RX_POP);
    assign sel_rx_count = (bus.address == ADDR_RX_COUNT);
    assign sel_tx_push  = (bus.address == ADDR_TX_PUSH);
    assign sel_tx_free  = (bus.address == ADDR_TX_FREE);

    assign rx_pop_req  = bus.access && !bus.write_enable && sel_rx_pop;
    assign tx_push_req = bus.access &&  bus.write_enable && sel_tx_push;
    assign status_wr   = bus.access &&  bus.write_enable && sel_status;
    // TX fullness is judged on the registered count only, so a same-cycle
    // serializer pop never rescues a push into a full ring.
    assign tx_push     = tx_push_req && !tx_full;

    ring_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH), .OVERWRITE(RX_OVERWRITE)) u_rx_ring (
        .clock (clock),
        .reset (reset),
        .push  (bus.rx_valid),
        .pop   (rx_pop_req),
        .wdata (bus.rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    ring_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH), .OVERWRITE(1'b0)) u_tx_ring (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus.write_data),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_idle = (state_q == IDLE) && tx_empty;

    always_comb begin
        read_data = '0;
        if (sel_status) begin
            read_data[STAT_RX_OVF]      = rx_ovf_q;
            read_data[STAT_TX_OVF]      = tx_ovf_q;
            read_data[STAT_RX_NONEMPTY] = !rx_empty;
            read_data[STAT_TX_IDLE]     = tx_idle;
        end else if (sel_rx_pop) begin
            read_data = rx_empty ? '0 : rx_head;
        end else if (sel_rx_count) begin
            read_data = DATA_W'(rx_count);
        end else if (sel_tx_free) begin
            read_data = DATA_W'(TX_DEPTH) - DATA_W'(tx_count);
        end
    end

    always_comb begin
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        if (status_wr && bus.write_data[STAT_RX_OVF]) rx_ovf_d = 1'b0;
        if (status_wr && bus.write_data[STAT_TX_OVF]) tx_ovf_d = 1'b0;
        // A new overflow in the same cycle as a clear keeps the flag set.
        if (bus.rx_valid && rx_full && !rx_pop_req) rx_ovf_d = 1'b1;
        if (tx_push_req && tx_full)                  tx_ovf_d = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        sdata_d    = sdata_q;
        tx_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty && !bus.tx_busy) begin
                    state_d = SEND;
                    sdata_d = tx_head[{byte_idx_q, 3'b000} +: 8];
                end
            end
            SEND: begin
                state_d = GAP;
                if (byte_idx_q == BW'(BYTES - 1)) begin
                    tx_pop     = 1'b1;
                    byte_idx_d = '0;
                end else begin
                    byte_idx_d = byte_idx_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_ovf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            state_q    <= IDLE;
            byte_idx_q <= '0;
            sdata_q    <= '0;
        end else begin
            rx_ovf_q   <= rx_ovf_d;
            tx_ovf_q   <= tx_ovf_d;
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            sdata_q    <= sdata_d;
        end
    end

    assign bus.read_data = read_data;
    assign bus.tx_start  = (state_q == SEND);
    assign bus.sdata     = sdata_q;
    assign bus.irq       = !rx_empty || rx_ovf_q || tx_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_queue
// Brief    : Directed self-checking bench for mmio_uart_queue (two configs).
// Revision : 1.0
// ============================================================================
module tb_mmio_uart_queue;
    import mmio_uart_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mmio_uart_queue_if #(.DATA_W(32)) a_if ();
    mmio_uart_queue_if #(.DATA_W(32)) b_if ();

    mmio_uart_queue #(.DATA_W(32), .RX_DEPTH(4), .TX_DEPTH(8), .RX_OVERWRITE(1'b1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a_if)
    );

    mmio_uart_queue #(.DATA_W(32), .RX_DEPTH(2), .TX_DEPTH(2), .RX_OVERWRITE(1'b0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b_if)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_tx    = 0;
    logic [7:0] log_data [64];
    int         log_cyc  [64];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (a_if.tx_start === 1'b1 && n_tx < 64) begin
            log_data[n_tx] = a_if.sdata;
            log_cyc[n_tx]  = cyc;
            n_tx++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic a_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clock);
        a_if.access       = 1'b1;
        a_if.write_enable = 1'b0;
        a_if.address      = addr;
        #1 data = a_if.read_data;
        @(posedge clock);
        #1 a_if.access = 1'b0;
    endtask

    task automatic a_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        a_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic a_write(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clock);
        a_if.access       = 1'b1;
        a_if.write_enable = 1'b1;
        a_if.address      = addr;
        a_if.write_data   = wd;
        @(posedge clock);
        #1;
        a_if.access       = 1'b0;
        a_if.write_enable = 1'b0;
    endtask

    task automatic a_rx(input logic [31:0] wd);
        @(negedge clock);
        a_if.rx_valid = 1'b1;
        a_if.rx_data  = wd;
        @(posedge clock);
        #1 a_if.rx_valid = 1'b0;
    endtask

    // RX push and RX_POP read in the same cycle.
    task automatic a_push_pop(input logic [31:0] wd, output logic [31:0] data);
        @(negedge clock);
        a_if.rx_valid     = 1'b1;
        a_if.rx_data      = wd;
        a_if.access       = 1'b1;
        a_if.write_enable = 1'b0;
        a_if.address      = ADDR_RX_POP;
        #1 data = a_if.read_data;
        @(posedge clock);
        #1;
        a_if.rx_valid = 1'b0;
        a_if.access   = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int base;
        a_if.rx_valid = 0; a_if.rx_data = 0; a_if.access = 0; a_if.write_enable = 0;
        a_if.address = 0; a_if.write_data = 0; a_if.tx_busy = 0;
        b_if.rx_valid = 0; b_if.rx_data = 0; b_if.access = 0; b_if.write_enable = 0;
        b_if.address = 0; b_if.write_data = 0; b_if.tx_busy = 1;

        #2 reset = 1'b0;
        #20;
        check("rst_tx_start", 32'(a_if.tx_start), 32'h0);
        check("rst_sdata",    32'(a_if.sdata),    32'h0);
        check("rst_irq",      32'(a_if.irq),      32'h0);
        @(negedge clock) reset = 1'b1;

        // Config B: depth 2, drop-new overflow, access-qualified pop.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            b_if.rx_valid = 1'b1;
            b_if.rx_data  = 32'(i);
        end
        @(negedge clock) b_if.rx_valid = 1'b0;
        b_if.address = ADDR_RX_COUNT; #1 check("b_rx_count_full", b_if.read_data, 32'd2);
        b_if.address = ADDR_STATUS;   #1 check("b_status_ovf",    b_if.read_data, 32'hD);
        b_if.address = ADDR_TX_FREE;  #1 check("b_tx_free",       b_if.read_data, 32'd2);
        b_if.address = ADDR_RX_POP;   #1 check("b_peek_no_access", b_if.read_data, 32'd1);
        @(negedge clock);
        b_if.address = ADDR_RX_COUNT; #1 check("b_count_no_pop",  b_if.read_data, 32'd2);
        @(negedge clock);
        b_if.access = 1'b1; b_if.address = ADDR_RX_POP;
        #1 check("b_pop_oldest_kept", b_if.read_data, 32'd1);
        @(posedge clock); #1 b_if.access = 1'b0;
        b_if.address = ADDR_RX_POP;   #1 check("b_pop2", b_if.read_data, 32'd2);

        // Config A: reset view.
        a_chk("rx_count_rst", ADDR_RX_COUNT, 32'd0);
        a_chk("tx_free_rst",  ADDR_TX_FREE,  32'd8);
        a_chk("status_rst",   ADDR_STATUS,   32'h8);
        check("tx_start_idle", 32'(a_if.tx_start), 32'h0);
        a_chk("unmapped_rd",  32'hFFFF_FFF3, 32'd0);

        // Basic RX FIFO order.
        a_rx(32'hA1); a_rx(32'hB2); a_rx(32'hC3);
        a_write(ADDR_RX_COUNT, 32'hFF);
        a_chk("rx_count_3", ADDR_RX_COUNT, 32'd3);
        check("irq_nonempty", 32'(a_if.irq), 32'h1);
        a_chk("pop_a1", ADDR_RX_POP, 32'hA1);
        a_chk("pop_b2", ADDR_RX_POP, 32'hB2);
        a_chk("pop_c3", ADDR_RX_POP, 32'hC3);
        a_chk("pop_empty", ADDR_RX_POP, 32'h0);
        a_chk("rx_count_0", ADDR_RX_COUNT, 32'd0);
        a_chk("status_empty", ADDR_STATUS, 32'h8);

        // Overwrite-oldest on a full depth-4 ring.
        for (int i = 1; i <= 5; i++) a_rx(32'(i));
        a_chk("ovw_count", ADDR_RX_COUNT, 32'd4);
        a_chk("ovw_status", ADDR_STATUS, 32'hD);
        check("ovw_irq", 32'(a_if.irq), 32'h1);
        a_chk("ovw_pop_2", ADDR_RX_POP, 32'd2);
        a_write(ADDR_STATUS, 32'h1);
        a_chk("ovf_cleared", ADDR_STATUS, 32'hC);
        a_chk("ovw_pop_3", ADDR_RX_POP, 32'd3);
        a_chk("ovw_pop_4", ADDR_RX_POP, 32'd4);
        a_chk("ovw_pop_5", ADDR_RX_POP, 32'd5);

        // Push + pop on a full ring: no overflow, count unchanged.
        a_rx(32'h11); a_rx(32'h22); a_rx(32'h33); a_rx(32'h44);
        a_push_pop(32'h99, d);
        check("pp_full_head", d, 32'h11);
        a_chk("pp_full_count", ADDR_RX_COUNT, 32'd4);
        a_chk("pp_full_status", ADDR_STATUS, 32'hC);
        a_chk("pp_pop_22", ADDR_RX_POP, 32'h22);
        a_chk("pp_pop_33", ADDR_RX_POP, 32'h33);
        a_chk("pp_pop_44", ADDR_RX_POP, 32'h44);
        a_chk("pp_pop_99", ADDR_RX_POP, 32'h99);
        // Push + pop on an empty ring: read 0, pushed word stays.
        a_push_pop(32'h55, d);
        check("pp_empty_rd", d, 32'h0);
        a_chk("pp_empty_count", ADDR_RX_COUNT, 32'd1);
        a_chk("pp_pop_55", ADDR_RX_POP, 32'h55);

        // One word serialized LSB byte first, pulses 3 cycles apart.
        base = n_tx;
        a_write(ADDR_TX_PUSH, 32'h4433_2211);
        for (int k = 0; k < 60 && n_tx < base + 4; k++) @(negedge clock);
        check("tx_pulses", 32'(n_tx - base), 32'd4);
        check("tx_b0", 32'(log_data[base]),     32'h11);
        check("tx_b1", 32'(log_data[base + 1]), 32'h22);
        check("tx_b2", 32'(log_data[base + 2]), 32'h33);
        check("tx_b3", 32'(log_data[base + 3]), 32'h44);
        for (int j = 1; j < 4; j++)
            check("tx_gap", 32'(log_cyc[base + j] - log_cyc[base + j - 1]), 32'd3);
        repeat (4) @(negedge clock);
        a_chk("tx_free_back", ADDR_TX_FREE, 32'd8);
        a_chk("tx_idle_status", ADDR_STATUS, 32'h8);

        // TX overflow while the transmitter is busy.
        a_if.tx_busy = 1'b1;
        for (int i = 1; i <= 9; i++) a_write(ADDR_TX_PUSH, {4{8'(i)}});
        a_chk("tx_free_full", ADDR_TX_FREE, 32'd0);
        a_chk("tx_ovf_status", ADDR_STATUS, 32'h2);
        check("tx_ovf_irq", 32'(a_if.irq), 32'h1);
        base = n_tx;
        a_if.tx_busy = 1'b0;
        for (int k = 0; k < 200 && n_tx < base + 32; k++) @(negedge clock);
        repeat (30) @(negedge clock);
        check("tx_8_words", 32'(n_tx - base), 32'd32);
        check("tx_first_byte", 32'(log_data[base]),      32'h01);
        check("tx_mid_byte",   32'(log_data[base + 16]), 32'h05);
        check("tx_last_byte",  32'(log_data[base + 31]), 32'h08);
        a_write(ADDR_STATUS, 32'h2);
        a_chk("tx_ovf_cleared", ADDR_STATUS, 32'h8);
        check("irq_clear", 32'(a_if.irq), 32'h0);

        // Reset asserted during SEND.
        a_write(ADDR_TX_PUSH, 32'h0000_00AB);
        for (int k = 0; k < 20 && a_if.tx_start !== 1'b1; k++) @(negedge clock);
        check("send_seen", 32'(a_if.tx_start), 32'h1);
        check("send_sdata", 32'(a_if.sdata), 32'hAB);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_tx_start", 32'(a_if.tx_start), 32'h0);
        check("rst_mid_sdata",    32'(a_if.sdata),    32'h0);
        @(negedge clock) reset = 1'b1;
        base = n_tx;
        a_chk("rst_tx_free", ADDR_TX_FREE, 32'd8);
        repeat (10) @(negedge clock);
        check("rst_no_resend", 32'(n_tx - base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
